// File: rtl/f3m_pkg.sv
// Shared GF(3) / GF(3^97) definitions: field size, trit codes, FSM states and
// the trit arithmetic primitives used across the pairing datapath.
package f3m_pkg;

    localparam int M     = 97;
    localparam int WIDTH = 2*M-1;
    localparam logic [2*M+1:0] PX = 196'h4000000000000000000000000000000000000000001000002;

    localparam logic [1:0] ZERO = 2'b00;
    localparam logic [1:0] ONE  = 2'b01;
    localparam logic [1:0] TWO  = 2'b10;

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    // Code 11 is not a legal trit; it is treated as 0 everywhere.
    function automatic logic [1:0] f3_norm(input logic [1:0] x);
        return (x == 2'b11) ? ZERO : x;
    endfunction

    function automatic logic [1:0] f3_neg(input logic [1:0] x);
        case (f3_norm(x))
            ONE:     return TWO;
            TWO:     return ONE;
            default: return ZERO;
        endcase
    endfunction

    function automatic logic [1:0] f3_add(input logic [1:0] x, input logic [1:0] y);
        logic [2:0] sum;
        sum = {1'b0, f3_norm(x)} + {1'b0, f3_norm(y)};
        case (sum)
            3'd1:    return ONE;
            3'd2:    return TWO;
            3'd4:    return ONE;
            default: return ZERO;
        endcase
    endfunction

    function automatic logic [1:0] f3_sub(input logic [1:0] x, input logic [1:0] y);
        return f3_add(x, f3_neg(y));
    endfunction

    function automatic logic [1:0] f3_mult(input logic [1:0] x, input logic [1:0] y);
        case ({f3_norm(x), f3_norm(y)})
            4'b0101: return ONE;
            4'b0110: return TWO;
            4'b1001: return TWO;
            4'b1010: return ONE;
            default: return ZERO;
        endcase
    endfunction

endpackage

// File: rtl/f3m_mac_step.sv
// One Horner step of the serial multiplier: znext = x*z mod p + d*a.
// Relies on x^97 = 2x^12 + 1, so the trit leaving position 96 folds back into trits 0 and 12.
module f3m_mac_step
    import f3m_pkg::*;
(
    input  logic [WIDTH:0] z,
    input  logic [WIDTH:0] a,
    input  logic [1:0]     d,
    output logic [WIDTH:0] znext
);

    localparam int TAP = 12;

    logic [1:0]     top_s;
    logic [WIDTH:0] shift_s;
    logic [WIDTH:0] red_s;

    // Shift by x, fold the overflow trit back, then accumulate d*a trit by trit.
    always_comb begin
        top_s   = z[WIDTH -: 2];
        shift_s = {z[WIDTH-2:0], ZERO};
        red_s   = shift_s;
        red_s[1:0]           = f3_add(shift_s[1:0], top_s);
        red_s[2*TAP +: 2]    = f3_add(shift_s[2*TAP +: 2], f3_mult(TWO, top_s));
        znext = '0;
        for (int i = 0; i < M; i++) begin
            znext[2*i +: 2] = f3_add(red_s[2*i +: 2], f3_mult(d, a[2*i +: 2]));
        end
    end

endmodule

// File: rtl/f3m_mult_serial.sv
// Sequential GF(3^97) multiplier: one trit of B per clock, MSB first,
// M iteration cycles per product, start/busy/done handshake.
module f3m_mult_serial
    import f3m_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [WIDTH:0] a,
    input  logic [WIDTH:0] b,
    output logic           busy,
    output logic           done,
    output logic [WIDTH:0] c
);

    state_t         state_r;
    logic [6:0]     cnt_r;
    logic [WIDTH:0] a_r;
    logic [WIDTH:0] b_r;
    logic [WIDTH:0] z_r;
    logic [WIDTH:0] znext_s;
    logic [7:0]     idx_s;
    logic [1:0]     digit_s;

    // Select the current trit of B, walking from trit M-1 down to 0.
    always_comb begin
        idx_s   = {cnt_r, 1'b0};
        digit_s = b_r[idx_s +: 2];
    end

    f3m_mac_step u_mac (
        .z     (z_r),
        .a     (a_r),
        .d     (digit_s),
        .znext (znext_s)
    );

    // Control FSM, iteration counter, operand/accumulator and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 7'd0;
            a_r     <= '0;
            b_r     <= '0;
            z_r     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            c       <= '0;
        end else begin
            done <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        z_r     <= '0;
                        cnt_r   <= 7'(M-1);
                        busy    <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    z_r <= znext_s;
                    if (cnt_r == 7'd0) begin
                        c       <= znext_s;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        cnt_r <= cnt_r - 7'd1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_f3m_mult_serial.sv
// Scoreboard bench for f3m_mult_serial: expected products come from a schoolbook
// polynomial multiply followed by reduction with x^97 = 2x^12 + 1.
module tb_f3m_mult_serial;
    import f3m_pkg::*;

    localparam int W = 2*M;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] c;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [W-1:0] val;
        int           due;
    } exp_t;
    exp_t sb[$];
    logic [W-1:0] hold_c = '0;

    f3m_mult_serial dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .c     (c)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int px[M];
        int py[M];
        int pr[2*M-1];
        int k0;
        logic [W-1:0] r;
        for (int i = 0; i < M; i++) begin
            px[i] = int'(x[2*i +: 2]);
            py[i] = int'(y[2*i +: 2]);
            if (px[i] == 3) px[i] = 0;
            if (py[i] == 3) py[i] = 0;
        end
        for (int i = 0; i < 2*M-1; i++) pr[i] = 0;
        for (int i = 0; i < M; i++)
            for (int j = 0; j < M; j++)
                pr[i+j] += px[i] * py[j];
        for (int k = 2*M-2; k >= M; k--) begin
            k0 = pr[k] % 3;
            pr[k] = 0;
            pr[k-M+12] += 2 * k0;
            pr[k-M]    += k0;
        end
        r = '0;
        for (int i = 0; i < M; i++) r[2*i +: 2] = 2'(pr[i] % 3);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_elem(input bit allow_bad);
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < M; i++)
            r[2*i +: 2] = allow_bad ? 2'($urandom_range(0, 3)) : 2'($urandom_range(0, 2));
        return r;
    endfunction

    task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Wait for idle, present operands for one edge, and record the expected result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] expv, input bit track, output int acc);
        int guard;
        guard = 0;
        @(negedge clk);
        while (busy !== 1'b0 && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300) begin
            vectors++;
            miscompares++;
            $display("FAIL busy_timeout: busy still %b, expected 0 within 300 cycles", busy);
        end
        a = av;
        b = bv;
        start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (track) sb.push_back('{val: expv, due: cyc + M});
        @(negedge clk);
        start = 1'b0;
        a = rand_elem(1'b1);
        b = rand_elem(1'b1);
    endtask

    // Monitor: every done must match the scoreboard head and its due cycle; c must hold otherwise.
    always @(posedge clk) begin
        #1;
        if (reset) hold_c = '0;
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done at cycle %0d: got c=%h expected no done", cyc, c);
                hold_c = c;
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_vec("product", c, e.val);
                check_int("latency", cyc, e.due);
                hold_c = e.val;
            end
        end else if (c !== hold_c) begin
            miscompares++;
            $display("FAIL hold: got c=%h expected %h", c, hold_c);
            hold_c = c;
        end
    end

    initial begin
        logic [W-1:0] one_v;
        logic [W-1:0] xa, xb, p1a, p1b, p2a, p2b, p3a, p3b;
        int n0;
        int guard;

        one_v = 1;

        repeat (3) @(posedge clk);
        #1;
        check_int("reset_busy", int'(busy), 0);
        check_int("reset_done", int'(done), 0);
        check_vec("reset_c", c, '0);
        @(negedge clk);
        reset = 1'b0;

        // Directed products with hand-derived results.
        xa = rand_elem(1'b0);
        run_op(xa, one_v, xa, 1'b1, n0);
        run_op(one_v << 2, one_v << 192, (one_v << 25) | one_v, 1'b1, n0);
        run_op(one_v << 2, (one_v << 192) | (one_v << 22), one_v, 1'b1, n0);
        run_op(one_v << 1, one_v << 1, one_v, 1'b1, n0);
        xb = rand_elem(1'b0);
        run_op(xb, '0, '0, 1'b1, n0);
        run_op(xa, one_v | (one_v << 10) | (one_v << 11), xa, 1'b1, n0);

        // A start while busy is ignored; a held start chains back-to-back products.
        p1a = rand_elem(1'b0); p1b = rand_elem(1'b0);
        p2a = rand_elem(1'b0); p2b = rand_elem(1'b0);
        p3a = rand_elem(1'b0); p3b = rand_elem(1'b0);
        run_op(p1a, p1b, ref_mul(p1a, p1b), 1'b1, n0);
        wait_cyc(n0 + 39);
        a = p2b; b = p2a; start = 1'b1;
        @(posedge clk);
        #1;
        check_int("busy_during_run", int'(busy), 1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = p2a; b = p2b; start = 1'b1;
        wait_cyc(n0 + 98);
        sb.push_back('{val: ref_mul(p2a, p2b), due: n0 + 98 + M});
        a = p3a; b = p3b;
        wait_cyc(n0 + 196);
        sb.push_back('{val: ref_mul(p3a, p3b), due: n0 + 196 + M});
        start = 1'b0;

        // Reset mid-operation aborts without a done; a later start works normally.
        p1a = rand_elem(1'b0); p1b = rand_elem(1'b0);
        run_op(p1a, p1b, '0, 1'b0, n0);
        wait_cyc(n0 + 49);
        check_int("busy_before_reset", int'(busy), 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_int("abort_busy", int'(busy), 0);
        check_int("abort_done", int'(done), 0);
        check_vec("abort_c", c, '0);
        @(negedge clk);
        reset = 1'b0;
        repeat (150) @(negedge clk);
        run_op(p1b, p1a, ref_mul(p1b, p1a), 1'b1, n0);

        // Random operands, some carrying illegal 11 digits.
        for (int k = 0; k < 150; k++) begin
            bit bad;
            bad = ($urandom_range(0, 4) == 0);
            xa = rand_elem(bad);
            xb = rand_elem(bad);
            run_op(xa, xb, ref_mul(xa, xb), 1'b1, n0);
        end

        guard = 0;
        while (sb.size() != 0 && guard < 400) begin
            @(negedge clk);
            guard++;
        end
        check_int("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
